uart_rx_sampler: RTL
====================

// Module: uart_rx_sampler
// PURPOSE
//  Oversampling UART receiver (8N1, LSB first) feeding the Disk controller's serial command path.
//  Synchronises RxD, validates the start bit, and majority-votes the centre of every bit.
//  Each received byte is presented with a 1-cycle strobe. Also reports framing errors and
//  end-of-packet line idle, which Disk uses to delimit host commands.
// PARAMETERS
//  CLK_FREQ    100_000_000  clk frequency, Hz
//  BAUD        115200       line rate, bit/s
//  OVERSAMPLE  16           os_ticks per bit; even, >=8
//  GAP_BITS    10           idle bit-times that end a packet
// PORTS
//  clk               in   1  system clock, rising edge
//  rst               in   1  asynchronous reset, active-high
//  RxD               in   1  raw serial input (asynchronous, mark = 1)
//  RxD_data          out  8  last received byte; held until the next valid byte
//  RxD_data_ready    out  1  1-cycle strobe, RxD_data valid
//  RxD_frame_err     out  1  1-cycle strobe, stop bit sampled 0
//  RxD_idle          out  1  line idle >= GAP_BITS bit-times
//  RxD_endofpacket   out  1  1-cycle strobe on idle onset after >=1 byte
//  Rx_busy           out  1  1 while state != IDLE
// BEHAVIOUR
//  Reset: all outputs 0. Synchroniser flops = 1. State = IDLE. Counters = 0. Takes effect immediately, also mid-frame.
//  Synchroniser: 2 flops on RxD; all logic uses the second flop (rxs).
//  Tick generator: DIV = (CLK_FREQ + BAUD*OVERSAMPLE/2) / (BAUD*OVERSAMPLE), rounded; defaults give 54.
//   os_tick is a 1-clk pulse every DIV clks. The divider is free-running.
//  sc: sample counter, log2(OVERSAMPLE) bits, advances on os_tick; bitcnt 3 bits.
//  Majority: samples taken on os_ticks with sc = M-1, M, M+1, where M = OVERSAMPLE/2.
//   The bit value is the 2-of-3 vote, decided at sc = M+1.
//  FSM:
//   IDLE: on os_tick with rxs=0 -> START, sc=0.
//   START: at vote, 1 -> IDLE (glitch reject, no output);
//    0 -> continue to sc wrap (OVERSAMPLE-1), then DATA with bitcnt=0.
//   DATA: at vote, shift the bit in at MSB (LSB first on the line).
//    At sc wrap, bitcnt++; after bitcnt=7 -> STOP.
//   STOP: at vote, 1 -> RxD_data <= shreg, RxD_data_ready pulses on the next clk, -> IDLE
//    (mid-stop, so a back-to-back start bit is caught).
//    0 -> RxD_frame_err pulses, RxD_data unchanged, -> BREAK.
//   BREAK: wait for os_tick with rxs=1 -> IDLE.
//  Latency: strobe asserts exactly 1 clk after the os_tick carrying the stop-bit vote.
//   A frame start to strobe is ~9.5 bit-times plus 2-4 clks.
//  Idle: gap counter counts os_ticks in IDLE with rxs=1 and saturates at GAP_BITS*OVERSAMPLE.
//   On reaching it: RxD_idle <= 1. RxD_endofpacket pulses once if a byte has been
//   received since the last idle, then that flag clears.
//   The gap counter clears and RxD_idle drops on entering START (including glitch starts).
//  data_ready and frame_err are never asserted in the same cycle.
//   No consumer back-pressure: a new byte overwrites RxD_data.
// TESTING (bench params CLK_FREQ=64*BAUD, OVERSAMPLE=16 -> DIV=4, 64 clk/bit)
//  1 Frame 0xA5, 1 stop -> RxD_data=8'hA5, RxD_data_ready high exactly 1 clk, RxD_frame_err=0,
//    Rx_busy low after the strobe.
//  2 Frame 0x3C with stop=0, hold low 2 bits, then frame 0x55 -> one frame_err pulse, no ready,
//    RxD_data stays at prior value; next byte 0x55 ready.
//  3 RxD low for 3 os_ticks (12 clk) then high -> no strobe, no frame_err, FSM back in IDLE,
//    RxD_idle drops then re-asserts after 10 bit-times.
//  4 Back-to-back 0x00, 0xFF, 0x81 with zero gap -> three ready strobes, data in order.
//  5 After byte 0x12, line high 10 bit-times -> RxD_idle=1 and one RxD_endofpacket pulse;
//    a further 20 bit-times of idle -> no second pulse.
//  6 Assert rst mid-DATA of 0x7E, release, then send 0x81 -> outputs 0 during reset,
//    no strobe for 0x7E, 0x81 received correctly.
//  7 Single 1-clk low glitch inside a data bit centre -> majority vote keeps the correct byte (0xF0).

Source files
------------

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler
//  Oversampling 8N1 UART receiver (LSB first) for the Disk controller's
//  serial command path. RxD is synchronised through two flops. The start bit
//  is validated. Every bit is decided by a 2-of-3 vote around its centre.
//  The receiver also flags framing errors and the idle line that ends a packet.
//
//  Output protocol: there is no valid/ready handshake and no back-pressure.
//  RxD_data_ready is a single-cycle strobe that qualifies RxD_data.
//  RxD_data holds its value until the next good byte overwrites it.
//  RxD_frame_err and RxD_endofpacket are also single-cycle strobes.
//  RxD_data_ready and RxD_frame_err never assert together.
//
//  Ports
//   clk              in   system clock, rising edge
//   rst              in   asynchronous reset, active-high
//   RxD              in   raw serial input (asynchronous, mark = 1)
//   RxD_data         out  last received byte
//   RxD_data_ready   out  1-cycle strobe, RxD_data valid
//   RxD_frame_err    out  1-cycle strobe, stop bit sampled 0
//   RxD_idle         out  line idle for >= GAP_BITS bit-times
//   RxD_endofpacket  out  1-cycle strobe on idle onset after >= 1 byte
//   Rx_busy          out  receiver FSM not in IDLE
//   state_dbg        out  current FSM state encoding, for debug/checkers
module uart_rx_sampler #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned GAP_BITS   = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RxD,
  output logic [7:0] RxD_data,
  output logic       RxD_data_ready,
  output logic       RxD_frame_err,
  output logic       RxD_idle,
  output logic       RxD_endofpacket,
  output logic       Rx_busy,
  output logic [2:0] state_dbg
);

  // Tick divider, rounded to the nearest integer.
  localparam int unsigned DIV = 32'((64'(CLK_FREQ) + (64'(BAUD) * 64'(OVERSAMPLE)) / 2)
                                    / (64'(BAUD) * 64'(OVERSAMPLE)));
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SC_W    = $clog2(OVERSAMPLE);
  localparam int GAP_MAX = GAP_BITS * OVERSAMPLE;
  localparam int GAP_W   = $clog2(GAP_MAX + 1);

  localparam logic [SC_W-1:0] SC_LAST = SC_W'(OVERSAMPLE - 1);
  localparam logic [SC_W-1:0] SC_PRE  = SC_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SC_W-1:0] SC_MID  = SC_W'(OVERSAMPLE / 2);
  localparam logic [SC_W-1:0] SC_POST = SC_W'(OVERSAMPLE / 2 + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  state_t            state, state_next;
  logic [DIV_W-1:0]  div_cnt;
  logic              os_tick;
  logic              rxd_meta, rxs;
  logic [SC_W-1:0]   sc;
  logic [2:0]        bitcnt;
  logic [7:0]        shreg;
  logic              s_pre, s_mid;
  logic              vote, at_vote, at_wrap;
  logic              byte_ok, frame_bad, enter_start;
  logic [GAP_W-1:0]  gap_cnt;
  logic              got_byte;

  // Free-running oversample tick.
  assign os_tick = (div_cnt == DIV_W'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) div_cnt <= '0;
    else if (os_tick) div_cnt <= '0;
    else div_cnt <= div_cnt + DIV_W'(1);
  end

  // Two-flop synchroniser, reset to mark so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_meta <= 1'b1;
      rxs      <= 1'b1;
    end else begin
      rxd_meta <= RxD;
      rxs      <= rxd_meta;
    end
  end

  // The third sample is rxs itself on the deciding tick.
  assign vote    = (s_pre & s_mid) | (s_pre & rxs) | (s_mid & rxs);
  assign at_vote = os_tick && (sc == SC_POST);
  assign at_wrap = os_tick && (sc == SC_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else state <= state_next;
  end

  always_comb begin
    state_next  = state;
    byte_ok     = 1'b0;
    frame_bad   = 1'b0;
    enter_start = 1'b0;
    case (state)
      ST_IDLE: begin
        if (os_tick && !rxs) begin
          state_next  = ST_START;
          enter_start = 1'b1;
        end
      end
      ST_START: begin
        // A start bit that votes high was a glitch.
        if (at_vote && vote) state_next = ST_IDLE;
        else if (at_wrap) state_next = ST_DATA;
      end
      ST_DATA: begin
        if (at_wrap && bitcnt == 3'd7) state_next = ST_STOP;
      end
      ST_STOP: begin
        // Leave at mid-stop so a back-to-back start edge is not missed.
        if (at_vote) begin
          if (vote) begin
            byte_ok    = 1'b1;
            state_next = ST_IDLE;
          end else begin
            frame_bad  = 1'b1;
            state_next = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        if (os_tick && rxs) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Sample counter sits at 0 in IDLE. The detecting tick therefore counts as sc = 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sc <= '0;
    else if (state == ST_IDLE) sc <= '0;
    else if (os_tick) sc <= (sc == SC_LAST) ? '0 : sc + SC_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_pre  <= 1'b1;
      s_mid  <= 1'b1;
      bitcnt <= '0;
      shreg  <= '0;
    end else begin
      if (os_tick && sc == SC_PRE) s_pre <= rxs;
      if (os_tick && sc == SC_MID) s_mid <= rxs;
      if (state == ST_START) bitcnt <= '0;
      else if (state == ST_DATA && at_wrap) bitcnt <= bitcnt + 3'd1;
      // LSB arrives first, so shift in at the MSB.
      if (state == ST_DATA && at_vote) shreg <= {vote, shreg[7:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RxD_data        <= '0;
      RxD_data_ready  <= 1'b0;
      RxD_frame_err   <= 1'b0;
      RxD_idle        <= 1'b0;
      RxD_endofpacket <= 1'b0;
      gap_cnt         <= '0;
      got_byte        <= 1'b0;
    end else begin
      RxD_data_ready  <= byte_ok;
      RxD_frame_err   <= frame_bad;
      RxD_endofpacket <= 1'b0;
      if (byte_ok) begin
        RxD_data <= shreg;
        got_byte <= 1'b1;
      end
      if (enter_start) begin
        gap_cnt  <= '0;
        RxD_idle <= 1'b0;
      end else if (state == ST_IDLE && os_tick && rxs && gap_cnt != GAP_W'(GAP_MAX)) begin
        gap_cnt <= gap_cnt + GAP_W'(1);
        if (gap_cnt == GAP_W'(GAP_MAX - 1)) begin
          RxD_idle        <= 1'b1;
          RxD_endofpacket <= got_byte;
          got_byte        <= 1'b0;
        end
      end
    end
  end

  assign Rx_busy   = (state != ST_IDLE);
  assign state_dbg = state;

endmodule
